lampfpu_fractdiv_iter: RTL

Iterative radix-2 restoring fraction divider for the bfloat16 FPU divide path. Produces the 16-bit fixed-point quotient and a one-cycle `valid_o` strobe consumed directly by the divide stage. That stage uses the quotient for exponent post-normalization, G/R/S extraction and rounding. One quotient bit is computed per clock, trading latency for area against a single-cycle DSP divide.

---
 rtl/lampfpu_fractdiv_iter_pkg.sv | 16 +
 rtl/lampfpu_fractdiv_step.sv | 22 ++
 rtl/lampfpu_fractdiv_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/lampfpu_fractdiv_iter_pkg.sv
// Shared constants and types for the bfloat16 fraction divider.
package lampfpu_fractdiv_iter_pkg;

  // Fraction width of bfloat16 (hidden bit not included).
  localparam int LAMP_FLOAT_F_DW = 7;

  // Number of quotient bits produced (one per clock).
  localparam int LAMP_FRACTDIV_ITER = 2 * (1 + LAMP_FLOAT_F_DW);

  // Divider control states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lampFractDivState_t;

endpackage

// File: rtl/lampfpu_fractdiv_step.sv
// One radix-2 restoring division step: compare, conditionally subtract, shift.
module lampfpu_fractdiv_step #(
  parameter int PW = 10  // partial remainder width; divisor is PW-1 bits
) (
  input  logic [PW-1:0] i_p,
  input  logic [PW-2:0] i_d,
  output logic          o_q,
  output logic [PW-1:0] o_p_next
);

  logic [PW-1:0] w_d_ext;
  logic [PW-1:0] w_diff;

  // Quotient bit is set whenever the divisor fits; the difference is doubled for the next bit.
  always_comb begin
    w_d_ext  = {1'b0, i_d};
    o_q      = (i_p >= w_d_ext);
    w_diff   = o_q ? (i_p - w_d_ext) : i_p;
    o_p_next = w_diff << 1;
  end

endmodule

// File: rtl/lampfpu_fractdiv_iter.sv
// Iterative radix-2 restoring fraction divider, one quotient bit per clock.
// Optional macro LAMP_FRACTDIV_STICKY_EN folds a nonzero final remainder into res_o[0].
module lampfpu_fractdiv_iter
  import lampfpu_fractdiv_iter_pkg::*;
#(
  parameter int MW = 1 + LAMP_FLOAT_F_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            doDiv_i,
  input  logic [MW-1:0]   n_i,
  input  logic [MW-1:0]   d_i,
  output logic [2*MW-1:0] res_o,
  output logic            valid_o,
  output logic            busy_o
);

  localparam int QW = 2 * MW;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] LAST_CNT = CW'(QW - 1);

  lampFractDivState_t r_state, w_state_next;

  logic [MW+1:0] r_p;
  logic [MW:0]   r_d;
  logic [QW-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic [QW-1:0] r_res;
  logic          r_valid;

  logic          w_load;
  logic          w_last;
  logic          w_q_bit;
  logic [MW+1:0] w_p_next;
  logic [QW-1:0] w_q_shift;
  logic [QW-1:0] w_res_final;

  lampfpu_fractdiv_step #(
    .PW (MW + 2)
  ) u_step (
    .i_p      (r_p),
    .i_d      (r_d),
    .o_q      (w_q_bit),
    .o_p_next (w_p_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; start pulses are only honoured in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (doDiv_i) begin
          w_load       = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shifted quotient including the bit produced this cycle, plus optional sticky fold.
  always_comb begin
    w_q_shift = {r_q[QW-2:0], w_q_bit};
`ifdef LAMP_FRACTDIV_STICKY_EN
    w_res_final = {w_q_shift[QW-1:1], w_q_shift[0] | (|w_p_next)};
`else
    w_res_final = w_q_shift;
`endif
  end

  // Datapath: operand load, per-cycle iteration and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= '0;
      r_d     <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_load) begin
        r_p   <= {2'b00, n_i};
        r_d   <= {d_i, 1'b0};
        r_q   <= '0;
        r_cnt <= '0;
      end else if (r_state == BUSY) begin
        r_p   <= w_p_next;
        r_q   <= w_q_shift;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) r_res <= w_res_final;
    end
  end

  assign res_o   = r_res;
  assign valid_o = r_valid;
  assign busy_o  = (r_state == BUSY);

endmodule
